// File: rtl/iob_ram_be_arbiter.sv
// Round-robin arbiter sharing one byte-enable RAM port between two requesters,
// with an optional power-up sweep that clears the RAM before serving requests.
//
//   state   | meaning
//   ST_INIT | sweeping the RAM with zeros, requests blocked
//   ST_RUN  | arbitrating m0/m1, one access per cycle
module iob_ram_be_arbiter #(
    parameter int NUM_COL   = 2,
    parameter int COL_WIDTH = 4,
    parameter int DATA_W    = NUM_COL * COL_WIDTH,
    parameter int ADDR_W    = 4,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_init_done,

    input  logic              i_m0_valid,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [NUM_COL-1:0] i_m0_wstrb,
    output logic              o_m0_ready,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_rvalid,

    input  logic              i_m1_valid,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [NUM_COL-1:0] i_m1_wstrb,
    output logic              o_m1_ready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_rvalid,

    output logic              o_ram_en,
    output logic [NUM_COL-1:0] o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_sweep_addr;
    logic                r_init_done;
    logic                r_ptr;          // 0: m0 wins a tie, 1: m1 wins a tie
    logic                r_rd_pend;
    logic                r_rd_owner;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_in_init;
    logic                w_run;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_rd_accept;
    logic                w_m0_rvalid;
    logic                w_m1_rvalid;

    // Reset gates the combinational drive so every output reads 0 while rst_n is low.
    assign w_in_init = rst_n && (r_state == ST_INIT);
    assign w_run     = rst_n && (r_state == ST_RUN);

    assign w_grant0 = w_run && i_m0_valid && (!i_m1_valid || !r_ptr);
    assign w_grant1 = w_run && i_m1_valid && (!i_m0_valid ||  r_ptr);

    assign w_rd_accept = (w_grant0 && (i_m0_wstrb == '0)) ||
                         (w_grant1 && (i_m1_wstrb == '0));

    assign o_m0_ready = w_grant0;
    assign o_m1_ready = w_grant1;

    always_comb begin
        o_ram_en   = 1'b0;
        o_ram_we   = '0;
        o_ram_addr = '0;
        o_ram_din  = '0;
        if (w_in_init) begin
            o_ram_en   = 1'b1;
            o_ram_we   = '1;
            o_ram_addr = r_sweep_addr;
        end else if (w_grant0) begin
            o_ram_en   = 1'b1;
            o_ram_we   = i_m0_wstrb;
            o_ram_addr = i_m0_addr;
            o_ram_din  = i_m0_wdata;
        end else if (w_grant1) begin
            o_ram_en   = 1'b1;
            o_ram_we   = i_m1_wstrb;
            o_ram_addr = i_m1_addr;
            o_ram_din  = i_m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET_STATE;
            r_sweep_addr <= '0;
            r_init_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_sweep_addr == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state <= RESET_STATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_grant0) begin
                r_ptr <= 1'b1;
            end else if (w_grant1) begin
                r_ptr <= 1'b0;
            end
            r_rd_pend  <= w_rd_accept;
            r_rd_owner <= w_grant1;
            if (w_m0_rvalid) begin
                r_m0_rdata <= i_ram_dout;
            end
            if (w_m1_rvalid) begin
                r_m1_rdata <= i_ram_dout;
            end
        end
    end

    // Read data is passed straight through in the return cycle and held afterwards.
    assign w_m0_rvalid = r_rd_pend && !r_rd_owner;
    assign w_m1_rvalid = r_rd_pend &&  r_rd_owner;

    assign o_m0_rvalid = w_m0_rvalid;
    assign o_m1_rvalid = w_m1_rvalid;
    assign o_m0_rdata  = w_m0_rvalid ? i_ram_dout : r_m0_rdata;
    assign o_m1_rdata  = w_m1_rvalid ? i_ram_dout : r_m1_rdata;
    assign o_init_done = r_init_done;

endmodule

// File: tb/tb_iob_ram_be_arbiter.sv
// Bench for iob_ram_be_arbiter: directed scenarios plus randomized traffic,
// checked against a memory-level model of the shared RAM and round-robin rule.
module tb_iob_ram_be_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       o_init_done;
    logic       m_valid [2];
    logic [3:0] m_addr  [2];
    logic [7:0] m_wdata [2];
    logic [1:0] m_wstrb [2];
    logic       o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid;
    logic [7:0] o_m0_rdata, o_m1_rdata;
    logic       ram_en;
    logic [1:0] ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    int total = 0;
    int bad   = 0;
    int dut_g;
    int g;

    // reference model state
    logic [7:0] ref_mem [16];
    int         nxt;
    logic       pend;
    int         pend_owner;
    logic [7:0] pend_data;
    logic [7:0] hold [2];

    always #5 clk = ~clk;

    iob_ram_be_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_init_done (o_init_done),
        .i_m0_valid  (m_valid[0]),
        .i_m0_addr   (m_addr[0]),
        .i_m0_wdata  (m_wdata[0]),
        .i_m0_wstrb  (m_wstrb[0]),
        .o_m0_ready  (o_m0_ready),
        .o_m0_rdata  (o_m0_rdata),
        .o_m0_rvalid (o_m0_rvalid),
        .i_m1_valid  (m_valid[1]),
        .i_m1_addr   (m_addr[1]),
        .i_m1_wdata  (m_wdata[1]),
        .i_m1_wstrb  (m_wstrb[1]),
        .o_m1_ready  (o_m1_ready),
        .o_m1_rdata  (o_m1_rdata),
        .o_m1_rvalid (o_m1_rvalid),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_din   (ram_din),
        .i_ram_dout  (ram_dout)
    );

    // byte-enable RAM with registered, read-first output
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr];
            for (int c = 0; c < 2; c++)
                if (ram_we[c]) ram_mem[ram_addr][c*4 +: 4] <= ram_din[c*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero();
        check("rst_init_done", 32'(o_init_done), 32'd0);
        check("rst_ready",     32'({o_m0_ready, o_m1_ready}), 32'd0);
        check("rst_rvalid",    32'({o_m0_rvalid, o_m1_rvalid}), 32'd0);
        check("rst_rdata",     32'({o_m0_rdata, o_m1_rdata}), 32'd0);
        check("rst_ram",       32'({ram_en, ram_we, ram_addr, ram_din}), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        nxt  = 0;
        pend = 1'b0;
        hold[0] = 8'h00;
        hold[1] = 8'h00;
    endtask

    // entered at posedge+1 right after reset release
    task automatic sweep_check();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("sweep_en",        32'(ram_en), 32'd1);
            check("sweep_we",        32'(ram_we), 32'd3);
            check("sweep_addr",      32'(ram_addr), 32'(k));
            check("sweep_din",       32'(ram_din), 32'd0);
            check("sweep_m0_ready",  32'(o_m0_ready), 32'd0);
            check("sweep_init_done", 32'(o_init_done), 32'd0);
            @(posedge clk);
            #1;
        end
        model_reset();
    endtask

    // one RUN cycle: check DUT against the model, then advance the model
    task automatic cycle(output int eg);
        int o;
        @(negedge clk);
        eg = -1;
        if (m_valid[0] && m_valid[1]) eg = nxt;
        else if (m_valid[0]) eg = 0;
        else if (m_valid[1]) eg = 1;
        dut_g = o_m1_ready ? 1 : (o_m0_ready ? 0 : -1);
        if (pend) hold[pend_owner] = pend_data;
        check("init_done", 32'(o_init_done), 32'd1);
        check("m0_ready",  32'(o_m0_ready), 32'(eg == 0));
        check("m1_ready",  32'(o_m1_ready), 32'(eg == 1));
        check("ram_en",    32'(ram_en), 32'(eg >= 0));
        if (eg >= 0) begin
            check("ram_addr", 32'(ram_addr), 32'(m_addr[eg]));
            check("ram_we",   32'(ram_we), 32'(m_wstrb[eg]));
            if (m_wstrb[eg] != 2'b00) check("ram_din", 32'(ram_din), 32'(m_wdata[eg]));
        end else begin
            check("ram_we_idle", 32'(ram_we), 32'd0);
        end
        check("m0_rvalid", 32'(o_m0_rvalid), 32'(pend && pend_owner == 0));
        check("m1_rvalid", 32'(o_m1_rvalid), 32'(pend && pend_owner == 1));
        check("m0_rdata",  32'(o_m0_rdata), 32'(hold[0]));
        check("m1_rdata",  32'(o_m1_rdata), 32'(hold[1]));
        @(posedge clk);
        pend = 1'b0;
        if (eg >= 0) begin
            o = eg;
            if (m_wstrb[o] == 2'b00) begin
                pend       = 1'b1;
                pend_owner = o;
                pend_data  = ref_mem[m_addr[o]];
            end else begin
                for (int c = 0; c < 2; c++)
                    if (m_wstrb[o][c]) ref_mem[m_addr[o]][c*4 +: 4] = m_wdata[o][c*4 +: 4];
            end
            nxt = 1 - o;
        end
        #1;
    endtask

    task automatic req(input int m, input logic [3:0] a, input logic [7:0] d, input logic [1:0] s);
        int gg;
        bit done;
        m_valid[m] = 1'b1;
        m_addr[m]  = a;
        m_wdata[m] = d;
        m_wstrb[m] = s;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            cycle(gg);
            if (gg == m) done = 1'b1;
        end
        if (!done) check("req_timeout", 32'd0, 32'd1);
        m_valid[m] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_addr[m] = 4'h0; m_wdata[m] = 8'h00; m_wstrb[m] = 2'b00;
        end
        model_reset();
        #1;
        m_valid[0] = 1'b1;
        #1;
        check_all_zero();
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check();
        m_valid[0] = 1'b0;

        // write then read back through m0
        req(0, 4'd3, 8'hA5, 2'b11);
        req(0, 4'd3, 8'h00, 2'b00);
        cycle(g);
        check("m0_rd_a5", 32'(o_m0_rdata), 32'hA5);
        check("m1_rvalid_quiet", 32'(o_m1_rvalid), 32'd0);

        // partial write keeps the upper column
        req(1, 4'd3, 8'h3C, 2'b01);
        req(1, 4'd3, 8'h00, 2'b00);
        cycle(g);
        check("m1_partial", 32'(o_m1_rdata), 32'hAC);
        check("m0_hold", 32'(o_m0_rdata), 32'hA5);

        // contention: alternating grants starting at m0
        req(0, 4'd1, 8'h5A, 2'b11);
        req(1, 4'd2, 8'h96, 2'b11);
        m_valid[0] = 1'b1; m_addr[0] = 4'd1; m_wstrb[0] = 2'b00;
        m_valid[1] = 1'b1; m_addr[1] = 4'd2; m_wstrb[1] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            check("contend_grant", 32'(dut_g), 32'(i % 2));
        end
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        cycle(g);
        check("contend_m0_data", 32'(o_m0_rdata), 32'h5A);
        check("contend_m1_data", 32'(o_m1_rdata), 32'h96);

        // pointer holds across idle cycles
        for (int first = 1; first >= 0; first--) begin
            req(first, 4'd5, 8'h00, 2'b00);
            for (int i = 0; i < 3; i++) cycle(g);
            m_valid[0] = 1'b1; m_addr[0] = 4'd6; m_wstrb[0] = 2'b00;
            m_valid[1] = 1'b1; m_addr[1] = 4'd7; m_wstrb[1] = 2'b00;
            cycle(g);
            check("ptr_hold_first", 32'(dut_g), 32'(1 - first));
            m_valid[1 - first] = 1'b0;
            cycle(g);
            check("ptr_hold_second", 32'(dut_g), 32'(first));
            m_valid[first] = 1'b0;
            cycle(g);
        end

        // randomized traffic, requests held until accepted
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_valid[m] && $urandom_range(0, 2) != 0) begin
                    m_valid[m] = 1'b1;
                    m_addr[m]  = 4'($urandom_range(0, 15));
                    m_wdata[m] = 8'($urandom);
                    m_wstrb[m] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
                end
            end
            cycle(g);
            if (g >= 0) m_valid[g] = 1'b0;
        end
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        cycle(g);

        // reset right after a read is accepted
        req(0, 4'd3, 8'h00, 2'b00);
        rst_n = 1'b0;
        #1;
        check_all_zero();
        @(negedge clk);
        check("rst_no_rvalid", 32'({o_m0_rvalid, o_m1_rvalid}), 32'd0);
        m_valid[0] = 1'b1; m_wstrb[0] = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check();
        m_valid[0] = 1'b0;
        req(1, 4'd3, 8'h00, 2'b00);
        cycle(g);
        check("post_rst_cleared", 32'(o_m1_rdata), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
